apb_master_bridge: RTL and testbench
====================================

# apb_master_bridge

Converts peripheral load/store requests from the memory stage into APB3 transfers and returns load data on `proc_rdata`. The bridge sits beside the data memory, driven by the memory-stage signals when the address decodes as peripheral (`IsPerM`). It stalls the pipeline until the transfer completes. It performs byte-lane steering, load extension, slave select decode, misalignment checks and a ready timeout.

## Interface
- `NSLV`, 3: number of APB slaves, 1..4; slave index is `PADDR[13:12]`.
- `TIMEOUT`, 255: maximum ACCESS cycles without `PREADY` before the transfer is aborted.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `proc_req`  in  1  peripheral access pending (IsPerM & (MemWriteM | load)); held stable while `proc_stall`=1.
- `proc_we`  in  1  1 = store, 0 = load.
- `proc_addr`  in  32  byte address (ALUResultM).
- `proc_wdata`  in  32  store data, low-aligned (WriteDataM).
- `proc_size`  in  2  00 byte, 01 half, 10 word (MemSizeM); 11 is treated as word.
- `proc_unsigned`  in  1  zero-extend loads (LBU/LHU).
- `proc_rdata`  out  32  extended load data, valid in DONE.
- `proc_stall`  out  1  stall to hazard unit.
- `proc_err`  out  1  one-cycle pulse in DONE on error.
- `PADDR`  out  32  APB address.
- `PSEL`  out  NSLV  one-hot slave select.
- `PENABLE`, `PWRITE`  out  1  APB control.
- `PWDATA`  out  32  lane-replicated write data.
- `PSTRB`  out  4  byte strobes; 0000 on reads.
- `PRDATA`  in  32  selected slave read data (externally muxed).
- `PREADY`, `PSLVERR`  in  1  selected slave response.

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE: if `proc_req`=1, register addr/we/size/unsigned/wdata, then check for an error condition.
  - Misaligned (half with addr[0]=1; word with addr[1:0]≠0) or index ≥ NSLV: go to DONE with err=1, rdata=0. No PSEL is asserted.
  - Otherwise go to SETUP.
- SETUP: PSEL[idx]=1, PENABLE=0. Go to ACCESS.
- ACCESS: PSEL[idx]=1, PENABLE=1; 8-bit wait counter increments.
  - If PREADY=1: capture extended PRDATA (reads) and PSLVERR, then go to DONE.
  - If the counter reaches TIMEOUT: go to DONE with err=1, rdata=0.
- DONE: `proc_stall`=0, `proc_err`=err. Go to IDLE unconditionally.
- On PSLVERR=1, `proc_rdata` is forced to 0.
- `proc_stall` = (IDLE & `proc_req`) | SETUP | ACCESS. It is combinational from the state and `proc_req`.
- Write steering:
  - PWDATA: byte is {4{wdata[7:0]}}, half is {2{wdata[15:0]}}, word is wdata.
  - PSTRB: byte is 0001<<addr[1:0], half is 0011<<addr[1:0], word is 1111.
- Read extraction:
  - Byte lane is PRDATA[8*addr[1:0] +: 8].
  - Half lane is PRDATA[16*addr[1] +: 16].
  - Sign-extend unless `proc_unsigned`=1.
- PADDR = registered addr, held from SETUP through ACCESS. PWRITE = registered we.

## Timing
- Reset (`rst`=0, asynchronous) forces state IDLE.
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0.
  - `proc_rdata`=0, `proc_err`=0, counter=0.
  - `proc_stall` follows `proc_req`.
- Reset mid-transfer drops PSEL/PENABLE immediately; no completion is reported.
- Minimum legal transfer with zero-wait PREADY:
  - Request seen in cycle 0 (IDLE).
  - SETUP in cycle 1, ACCESS in cycle 2, DONE in cycle 3.
  - `proc_stall` is high in cycles 0–2; the M/W register captures `proc_rdata` at the end of cycle 3.
- Each PREADY wait cycle adds one cycle.
- Error without a bus transaction: stall is high in cycle 0 only; DONE in cycle 1.
- A new request is accepted only in IDLE. The instruction that completed in DONE has advanced, so it is never re-issued.
- Back-to-back peripheral accesses: DONE → IDLE → SETUP, giving a minimum 4-cycle spacing.
- APB3 rule: PADDR/PWRITE/PWDATA/PSTRB/PSEL remain stable from SETUP until PREADY is sampled high.
- Flush cannot abort a transfer. The stall holds the pipeline, so no flush reaches the memory stage while `proc_stall`=1.

## Test plan
- Word store: addr 0x0000_1004, wdata 0xDEADBEEF, PREADY=1 → SETUP then ACCESS with PSEL=010, PSTRB=1111, PWDATA=0xDEADBEEF; stall is high for 3 cycles.
- Signed byte load: addr 0x0000_0003, PRDATA 0x80FF_0000 → `proc_rdata`=0xFFFF_FF80. The same load with `proc_unsigned`=1 → 0x0000_0080.
- Half store at addr 0x0000_2002, wdata 0x1234, with 5 PREADY-low cycles → PSTRB=1100, PWDATA=0x1234_1234, stall high for 8 cycles.
- Misaligned word load at 0x0000_1001, and a load with index 3 (addr 0x3000) → no PSEL, `proc_err` pulses in cycle 1, `proc_rdata`=0.
- PREADY held low → abort after TIMEOUT ACCESS cycles, `proc_err`=1. PSLVERR=1 on a read → `proc_rdata`=0, `proc_err`=1.
- `rst` asserted in ACCESS → PSEL/PENABLE drop to 0 without a clock edge. After release the FSM is in IDLE, and a held request is restarted from SETUP.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
// Processor-side request/response and APB3 bus signals of the peripheral bridge.
interface apb_master_bridge_if #(
  parameter int unsigned NSLV = 3
);
  // memory-stage side
  logic            proc_req;
  logic            proc_we;
  logic [31:0]     proc_addr;
  logic [31:0]     proc_wdata;
  logic [1:0]      proc_size;
  logic            proc_unsigned;
  logic [31:0]     proc_rdata;
  logic            proc_stall;
  logic            proc_err;
  // APB side
  logic [31:0]     PADDR;
  logic [NSLV-1:0] PSEL;
  logic            PENABLE;
  logic            PWRITE;
  logic [31:0]     PWDATA;
  logic [3:0]      PSTRB;
  logic [31:0]     PRDATA;
  logic            PREADY;
  logic            PSLVERR;

  // bridge view
  modport master (
    input  proc_req, proc_we, proc_addr, proc_wdata, proc_size, proc_unsigned,
    output proc_rdata, proc_stall, proc_err,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  // pipeline + peripheral view
  modport slave (
    output proc_req, proc_we, proc_addr, proc_wdata, proc_size, proc_unsigned,
    input  proc_rdata, proc_stall, proc_err,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Memory-stage peripheral load/store to APB3 master bridge with lane steering,
// load extension, slave decode, misalignment check and PREADY timeout.
module apb_master_bridge #(
  parameter int unsigned NSLV    = 3,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  apb_master_bridge_if.master bus
);

  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          r_state,   w_state_nxt;
  logic [31:0]     r_addr,    w_addr_nxt;
  logic            r_we,      w_we_nxt;
  logic [1:0]      r_size,    w_size_nxt;
  logic            r_uns,     w_uns_nxt;
  logic [CW-1:0]   r_cnt,     w_cnt_nxt;
  logic [NSLV-1:0] r_psel,    w_psel_nxt;
  logic            r_penable, w_penable_nxt;
  logic [31:0]     r_pwdata,  w_pwdata_nxt;
  logic [3:0]      r_pstrb,   w_pstrb_nxt;
  logic [31:0]     r_rdata,   w_rdata_nxt;
  logic            r_err,     w_err_nxt;

  logic            w_misaligned;
  logic            w_bad_idx;
  logic [CW-1:0]   w_cnt_inc;

  // Replicate store data across all byte lanes it may land on.
  function automatic logic [31:0] f_steer(input logic [31:0] d, input logic [1:0] sz);
    case (sz)
      2'b00:   f_steer = {4{d[7:0]}};
      2'b01:   f_steer = {2{d[15:0]}};
      default: f_steer = d;
    endcase
  endfunction

  // Byte strobes for the addressed lanes.
  function automatic logic [3:0] f_strb(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   f_strb = 4'b0001 << a;
      2'b01:   f_strb = 4'b0011 << a;
      default: f_strb = 4'b1111;
    endcase
  endfunction

  // Pick the addressed lane of read data and sign/zero-extend it.
  function automatic logic [31:0] f_extract(input logic [31:0] d, input logic [1:0] sz,
                                            input logic [1:0] a, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{a, 3'b000} +: 8];
    h = d[{a[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   f_extract = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   f_extract = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: f_extract = d;
    endcase
  endfunction

  // Request legality is judged on the live inputs while still in IDLE.
  assign w_misaligned = ((bus.proc_size == 2'b01) && bus.proc_addr[0]) ||
                        (bus.proc_size[1] && (bus.proc_addr[1:0] != 2'b00));
  assign w_bad_idx    = (32'(bus.proc_addr[13:12]) >= NSLV);
  assign w_cnt_inc    = r_cnt + CW'(1);

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_we_nxt      = r_we;
    w_size_nxt    = r_size;
    w_uns_nxt     = r_uns;
    w_cnt_nxt     = r_cnt;
    w_psel_nxt    = '0;
    w_penable_nxt = 1'b0;
    w_pwdata_nxt  = r_pwdata;
    w_pstrb_nxt   = r_pstrb;
    w_rdata_nxt   = r_rdata;
    w_err_nxt     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.proc_req) begin
          w_addr_nxt   = bus.proc_addr;
          w_we_nxt     = bus.proc_we;
          w_size_nxt   = bus.proc_size;
          w_uns_nxt    = bus.proc_unsigned;
          w_cnt_nxt    = '0;
          w_pwdata_nxt = f_steer(bus.proc_wdata, bus.proc_size);
          w_pstrb_nxt  = bus.proc_we ? f_strb(bus.proc_size, bus.proc_addr[1:0]) : 4'b0000;
          if (w_misaligned || w_bad_idx) begin
            w_state_nxt = S_DONE;
            w_err_nxt   = 1'b1;
            w_rdata_nxt = '0;
          end else begin
            w_state_nxt = S_SETUP;
            w_psel_nxt  = NSLV'(1) << bus.proc_addr[13:12];
          end
        end
      end
      S_SETUP: begin
        w_state_nxt   = S_ACCESS;
        w_psel_nxt    = r_psel;
        w_penable_nxt = 1'b1;
      end
      S_ACCESS: begin
        w_cnt_nxt = w_cnt_inc;
        if (bus.PREADY) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = bus.PSLVERR;
          w_rdata_nxt = (bus.PSLVERR || r_we) ? 32'd0
                                              : f_extract(bus.PRDATA, r_size, r_addr[1:0], r_uns);
        end else if (w_cnt_inc == CW'(TIMEOUT)) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = 1'b1;
          w_rdata_nxt = '0;
        end else begin
          w_psel_nxt    = r_psel;
          w_penable_nxt = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops the bus immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_size    <= '0;
      r_uns     <= 1'b0;
      r_cnt     <= '0;
      r_psel    <= '0;
      r_penable <= 1'b0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_we      <= w_we_nxt;
      r_size    <= w_size_nxt;
      r_uns     <= w_uns_nxt;
      r_cnt     <= w_cnt_nxt;
      r_psel    <= w_psel_nxt;
      r_penable <= w_penable_nxt;
      r_pwdata  <= w_pwdata_nxt;
      r_pstrb   <= w_pstrb_nxt;
      r_rdata   <= w_rdata_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Stall covers the accepting IDLE cycle and the whole bus transfer.
  assign bus.proc_stall = ((r_state == S_IDLE) && bus.proc_req) ||
                          (r_state == S_SETUP) || (r_state == S_ACCESS);

  assign bus.proc_rdata = r_rdata;
  assign bus.proc_err   = r_err;
  assign bus.PADDR      = r_addr;
  assign bus.PWRITE     = r_we;
  assign bus.PSEL       = r_psel;
  assign bus.PENABLE    = r_penable;
  assign bus.PWDATA     = r_pwdata;
  assign bus.PSTRB      = r_pstrb;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed plus randomized bench for apb_master_bridge with a behavioural model.
module tb_apb_master_bridge;

  localparam int unsigned NSLV    = 3;
  localparam int unsigned TIMEOUT = 255;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  // peripheral behaviour for the current transfer
  int          g_waits;
  logic [31:0] g_prdata;
  logic        g_slverr;
  int          acc_cnt;

  apb_master_bridge_if #(.NSLV(NSLV)) bus ();

  apb_master_bridge #(.NSLV(NSLV), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave: PREADY low for g_waits ACCESS cycles, then high with data/response.
  always @(negedge clk) begin
    if ((bus.PSEL != '0) && bus.PENABLE) begin
      bus.PREADY  = (acc_cnt == g_waits);
      bus.PRDATA  = (acc_cnt == g_waits) ? g_prdata : 32'h0;
      bus.PSLVERR = (acc_cnt == g_waits) ? g_slverr : 1'b0;
      acc_cnt     = acc_cnt + 1;
    end else begin
      bus.PREADY  = 1'b0;
      bus.PRDATA  = 32'h0;
      bus.PSLVERR = 1'b0;
      acc_cnt     = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: outcome of one request from the transfer rules alone.
  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns, input logic [31:0] prdata,
                       input int waits, input logic slverr,
                       output logic bus_exp, output logic [31:0] psel, output int stall,
                       output logic err, output logic [31:0] rdata,
                       output logic [31:0] pwdata, output logic [31:0] pstrb);
    int nbytes, idx, off, acc;
    logic [63:0] mask, lane;
    nbytes  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    idx     = int'((addr / 32'd4096) % 32'd4);
    off     = int'(addr % 32'd4);
    bus_exp = ((off % nbytes) == 0) && (idx < int'(NSLV));
    psel    = 32'd1 << idx;
    pstrb   = we ? (((32'd1 << nbytes) - 32'd1) << off) : 32'd0;
    pwdata  = (nbytes == 1) ? (wdata & 32'hFF) * 32'h0101_0101 :
              (nbytes == 2) ? (wdata & 32'hFFFF) * 32'h0001_0001 : wdata;
    rdata   = 32'd0;
    if (!bus_exp) begin
      stall = 1;
      err   = 1'b1;
    end else begin
      acc   = (waits < int'(TIMEOUT)) ? waits + 1 : int'(TIMEOUT);
      stall = 2 + acc;
      err   = (waits >= int'(TIMEOUT)) || slverr;
      if (!err && !we) begin
        mask = (64'd1 << (8 * nbytes)) - 64'd1;
        lane = ({32'd0, prdata} >> (8 * off)) & mask;
        if (!uns && lane[8 * nbytes - 1]) lane = lane | ~mask;
        rdata = lane[31:0];
      end
    end
  endtask

  // Issue one request, follow it to DONE and compare against the model.
  task automatic run(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                     input logic [31:0] prdata, input int waits, input logic slverr);
    logic bus_exp, e_err, done, saw, unstable, d_err, f_pen;
    logic [31:0] e_psel, e_rdata, e_pwdata, e_pstrb, d_rdata;
    logic [31:0] s_psel, s_paddr, s_pwdata, s_pstrb;
    logic s_pwrite;
    int e_stall, stall_cnt;
    model(we, addr, wdata, size, uns, prdata, waits, slverr,
          bus_exp, e_psel, e_stall, e_err, e_rdata, e_pwdata, e_pstrb);
    g_waits = waits; g_prdata = prdata; g_slverr = slverr;
    @(negedge clk);
    bus.proc_we = we; bus.proc_addr = addr; bus.proc_wdata = wdata;
    bus.proc_size = size; bus.proc_unsigned = uns; bus.proc_req = 1'b1;
    stall_cnt = 0; done = 1'b0; saw = 1'b0; unstable = 1'b0; f_pen = 1'b0;
    d_rdata = '0; d_err = 1'b0;
    s_psel = '0; s_paddr = '0; s_pwdata = '0; s_pstrb = '0; s_pwrite = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      #1;
      if (bus.PSEL != '0) begin
        if (!saw) begin
          saw = 1'b1; f_pen = bus.PENABLE;
          s_psel = 32'(bus.PSEL); s_paddr = bus.PADDR; s_pwrite = bus.PWRITE;
          s_pwdata = bus.PWDATA; s_pstrb = 32'(bus.PSTRB);
        end else if (s_psel != 32'(bus.PSEL) || s_paddr != bus.PADDR ||
                     s_pwrite != bus.PWRITE || s_pwdata != bus.PWDATA ||
                     s_pstrb != 32'(bus.PSTRB)) begin
          unstable = 1'b1;
        end
      end
      if (bus.proc_stall) begin
        stall_cnt++;
        @(negedge clk);
      end else begin
        done = 1'b1; d_rdata = bus.proc_rdata; d_err = bus.proc_err;
      end
    end
    bus.proc_req = 1'b0;
    check({tag, "_done"},  32'(done), 32'd1);
    check({tag, "_stall"}, 32'(stall_cnt), 32'(e_stall));
    check({tag, "_err"},   32'(d_err), 32'(e_err));
    check({tag, "_rdata"}, d_rdata, e_rdata);
    check({tag, "_busused"}, 32'(saw), 32'(bus_exp));
    if (bus_exp && saw) begin
      check({tag, "_psel"},   s_psel, e_psel);
      check({tag, "_penfirst"}, 32'(f_pen), 32'd0);
      check({tag, "_paddr"},  s_paddr, addr);
      check({tag, "_pwrite"}, 32'(s_pwrite), 32'(we));
      check({tag, "_pstrb"},  s_pstrb, e_pstrb);
      if (we) check({tag, "_pwdata"}, s_pwdata, e_pwdata);
      check({tag, "_stable"}, 32'(unstable), 32'd0);
    end
  endtask

  initial begin
    int waits;
    int k;
    logic [31:0] a;
    bus.proc_req = 1'b0; bus.proc_we = 1'b0; bus.proc_addr = '0; bus.proc_wdata = '0;
    bus.proc_size = '0; bus.proc_unsigned = 1'b0;
    bus.PRDATA = '0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
    g_waits = 0; g_prdata = '0; g_slverr = 1'b0; acc_cnt = 0;
    rst = 1'b0;

    // reset values
    #1;
    check("rst_psel",    32'(bus.PSEL), 32'd0);
    check("rst_penable", 32'(bus.PENABLE), 32'd0);
    check("rst_pwrite",  32'(bus.PWRITE), 32'd0);
    check("rst_paddr",   bus.PADDR, 32'd0);
    check("rst_pwdata",  bus.PWDATA, 32'd0);
    check("rst_pstrb",   32'(bus.PSTRB), 32'd0);
    check("rst_rdata",   bus.proc_rdata, 32'd0);
    check("rst_err",     32'(bus.proc_err), 32'd0);
    check("rst_stall0",  32'(bus.proc_stall), 32'd0);
    bus.proc_req = 1'b1;
    #1;
    check("rst_stall1",  32'(bus.proc_stall), 32'd1);
    bus.proc_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // directed cases
    run("wstore",  1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0, 0, 1'b0);
    run("lb_s",    1'b0, 32'h0000_0003, 32'h0,         2'b00, 1'b0, 32'h80FF_0000, 0, 1'b0);
    run("lb_u",    1'b0, 32'h0000_0003, 32'h0,         2'b00, 1'b1, 32'h80FF_0000, 0, 1'b0);
    run("hstore",  1'b1, 32'h0000_2002, 32'h0000_1234, 2'b01, 1'b0, 32'h0, 5, 1'b0);
    run("lh_s",    1'b0, 32'h0000_2002, 32'h0,         2'b01, 1'b0, 32'h9ABC_1234, 1, 1'b0);
    run("sb_lane", 1'b1, 32'h0000_0002, 32'h0000_00A5, 2'b00, 1'b0, 32'h0, 2, 1'b0);
    run("lw_sz3",  1'b0, 32'h0000_1008, 32'h0,         2'b11, 1'b0, 32'hCAFE_F00D, 0, 1'b0);
    run("misal",   1'b0, 32'h0000_1001, 32'h0,         2'b10, 1'b0, 32'h1111_1111, 0, 1'b0);
    @(negedge clk); #1;
    check("errpulse_end", 32'(bus.proc_err), 32'd0);
    run("idx3",    1'b0, 32'h0000_3000, 32'h0,         2'b10, 1'b0, 32'h2222_2222, 0, 1'b0);
    run("timeout", 1'b0, 32'h0000_0000, 32'h0,         2'b10, 1'b0, 32'h3333_3333, 1000, 1'b0);
    run("slverr",  1'b0, 32'h0000_1000, 32'h0,         2'b10, 1'b0, 32'h4444_4444, 1, 1'b1);

    // reset in ACCESS, then the held request restarts from SETUP
    g_waits = 10; g_prdata = 32'h0000_8001; g_slverr = 1'b0;
    @(negedge clk);
    bus.proc_we = 1'b0; bus.proc_addr = 32'h0000_0000; bus.proc_size = 2'b01;
    bus.proc_unsigned = 1'b0; bus.proc_req = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rstmid_pen_before", 32'(bus.PENABLE), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rstmid_psel",    32'(bus.PSEL), 32'd0);
    check("rstmid_penable", 32'(bus.PENABLE), 32'd0);
    check("rstmid_stall",   32'(bus.proc_stall), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    check("restart_psel", 32'(bus.PSEL), 32'd1);
    check("restart_pen",  32'(bus.PENABLE), 32'd0);
    k = 0;
    while (bus.proc_stall && k < 50) begin
      @(negedge clk); #1;
      k++;
    end
    check("restart_done",  32'(bus.proc_stall), 32'd0);
    check("restart_err",   32'(bus.proc_err), 32'd0);
    check("restart_rdata", bus.proc_rdata, 32'hFFFF_8001);
    bus.proc_req = 1'b0;

    // randomized requests
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      waits = int'($urandom_range(0, 3));
      run($sformatf("rnd%0d", i), 1'($urandom), a, $urandom, 2'($urandom), 1'($urandom),
          $urandom, waits, ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
